// File: rtl/theta_seq_if.sv
// Handshake and state-memory port bundle between theta_seq and the
// round controller / lane memory.
interface theta_seq_if #(parameter int W = 64);
    logic         start;
    logic         busy;
    logic         done;
    logic [2:0]   rx;
    logic [2:0]   ry;
    logic [W-1:0] rd;
    logic [2:0]   wx;
    logic [2:0]   wy;
    logic         wr;
    logic [W-1:0] wd;

    modport master (
        input  start, rd,
        output busy, done, rx, ry, wx, wy, wr, wd
    );

    modport slave (
        output start, rd,
        input  busy, done, rx, ry, wx, wy, wr, wd
    );
endinterface

// File: rtl/theta_seq.sv
// Keccak theta sequencer: parity sweep, D derivation, then in-place apply sweep.
// Optional debug parity export enabled by defining THETA_PAR_OUT_EN.
module theta_seq #(
    parameter int W = 64
) (
    input  logic          clk,
    input  logic          rst,
    theta_seq_if.master   bus
`ifdef THETA_PAR_OUT_EN
    ,
    output logic [5*W-1:0] par_out,
    output logic           par_vld
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PAR,
        S_DCALC,
        S_APPLY,
        S_DONE
    } state_t;

    state_t       r_state;
    state_t       w_next;
    logic [2:0]   r_x;
    logic [2:0]   r_y;
    logic [2:0]   w_x_nxt;
    logic [2:0]   w_y_nxt;
    logic         w_last;
    logic [W-1:0] r_c [5];
    logic [W-1:0] r_d [5];

    function automatic logic [W-1:0] rol1(input logic [W-1:0] v);
        return {v[W-2:0], v[W-1]};
    endfunction

    // Row-major lane walk: x inner, y outer, both wrapping at 4.
    always_comb begin
        w_last = (r_x == 3'd4) && (r_y == 3'd4);
        if (r_x == 3'd4) begin
            w_x_nxt = 3'd0;
            w_y_nxt = (r_y == 3'd4) ? 3'd0 : r_y + 3'd1;
        end else begin
            w_x_nxt = r_x + 3'd1;
            w_y_nxt = r_y;
        end
    end

    always_comb begin
        w_next   = r_state;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        bus.wr   = 1'b0;
        bus.wd   = '0;
        bus.rx   = r_x;
        bus.ry   = r_y;
        bus.wx   = r_x;
        bus.wy   = r_y;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_next = S_PAR;
            end
            S_PAR: begin
                bus.busy = 1'b1;
                if (w_last) w_next = S_DCALC;
            end
            S_DCALC: begin
                bus.busy = 1'b1;
                w_next   = S_APPLY;
            end
            S_APPLY: begin
                // rd is the pre-write value of the very lane being written.
                bus.busy = 1'b1;
                bus.wr   = 1'b1;
                bus.wd   = bus.rd ^ r_d[r_x];
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                bus.done = 1'b1;
                w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_x     <= 3'd0;
            r_y     <= 3'd0;
            for (int i = 0; i < 5; i++) begin
                r_c[i] <= '0;
                r_d[i] <= '0;
            end
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_x <= 3'd0;
                        r_y <= 3'd0;
                        for (int i = 0; i < 5; i++) r_c[i] <= '0;
                    end
                end
                S_PAR: begin
                    r_c[r_x] <= r_c[r_x] ^ bus.rd;
                    r_x      <= w_x_nxt;
                    r_y      <= w_y_nxt;
                end
                S_DCALC: begin
                    for (int i = 0; i < 5; i++)
                        r_d[i] <= r_c[(i + 4) % 5] ^ rol1(r_c[(i + 1) % 5]);
                    r_x <= 3'd0;
                    r_y <= 3'd0;
                end
                S_APPLY: begin
                    r_x <= w_x_nxt;
                    r_y <= w_y_nxt;
                end
                default: ;
            endcase
        end
    end

`ifdef THETA_PAR_OUT_EN
    // C is only cleared when the next pass is accepted, so the export holds until then.
    always_comb begin
        par_out = '0;
        for (int i = 0; i < 5; i++) par_out[i*W +: W] = r_c[i];
        par_vld = (r_state == S_DCALC);
    end
`endif

endmodule

// File: tb/tb_theta_seq.sv
// Bench for theta_seq: lane memory model plus an array-based theta reference.
module tb_theta_seq;
    localparam int W = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    theta_seq_if #(.W(W)) bus ();
`ifdef THETA_PAR_OUT_EN
    logic [5*W-1:0] par_out;
    logic           par_vld;
    logic [5*W-1:0] par_cap;
`endif

    theta_seq #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef THETA_PAR_OUT_EN
        ,
        .par_out (par_out),
        .par_vld (par_vld)
`endif
    );

    logic [W-1:0] mem    [5][5];
    logic [W-1:0] ld_img [5][5];
    logic [W-1:0] exp_m  [5][5];
    logic [W-1:0] orig   [5][5];
    logic         ld = 1'b0;

    assign bus.rd = mem[bus.rx][bus.ry];

    always @(posedge clk) begin
        if (ld) mem <= ld_img;
        else if (bus.wr) mem[bus.wx][bus.wy] <= bus.wd;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, want);
        end
    endtask

    task automatic load();
        @(negedge clk) ld = 1'b1;
        @(negedge clk) ld = 1'b0;
    endtask

    task automatic fill_const(input logic [W-1:0] v);
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++) ld_img[x][y] = v;
    endtask

    task automatic fill_rand();
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++) ld_img[x][y] = {$urandom(), $urandom()};
    endtask

    task automatic snap_exp();
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++) exp_m[x][y] = mem[x][y];
    endtask

    // One theta round on exp_m, straight from the column-parity definition.
    task automatic model_step();
        logic [W-1:0] c [5];
        logic [W-1:0] r;
        for (int x = 0; x < 5; x++) begin
            c[x] = '0;
            for (int y = 0; y < 5; y++) c[x] = c[x] ^ exp_m[x][y];
        end
        for (int x = 0; x < 5; x++) begin
            r = (c[(x + 1) % 5] << 1) | (c[(x + 1) % 5] >> (W - 1));
            for (int y = 0; y < 5; y++) exp_m[x][y] = exp_m[x][y] ^ c[(x + 4) % 5] ^ r;
        end
    endtask

    task automatic cmp_mem(input string tag);
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                check($sformatf("%s_lane%0d%0d", tag, x, y), mem[x][y], exp_m[x][y]);
    endtask

    // Accept one start; cycle k=1 is the first cycle after the accepting edge.
    task automatic run_pass(input int rst_at, output int done_k, output int wr_first,
                            output int wr_cnt, output int vld_cnt);
        done_k = 0; wr_first = 0; wr_cnt = 0; vld_cnt = 0;
        @(negedge clk) bus.start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done && done_k == 0) done_k = k;
            if (bus.wr) begin
                wr_cnt++;
                if (wr_first == 0) wr_first = k;
            end
`ifdef THETA_PAR_OUT_EN
            if (par_vld) begin
                vld_cnt++;
                par_cap = par_out;
            end
`endif
            if (rst_at < 0) begin
                if (k == 1)  check("busy_k1",  64'(bus.busy), 64'd1);
                if (k == 51) check("busy_k51", 64'(bus.busy), 64'd1);
                if (k == 52) check("busy_k52", 64'(bus.busy), 64'd0);
                if (k == 53) check("done_k53", 64'(bus.done), 64'd0);
            end
            if (k == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                check("rst_wr",   64'(bus.wr),   64'd0);
                check("rst_busy", 64'(bus.busy), 64'd0);
                check("rst_done", 64'(bus.done), 64'd0);
                rst = 1'b0;
                break;
            end
        end
    endtask

    int dk, wf, wc, vc, d1, d2;
    logic [W-1:0] want;

    initial begin
        bus.start = 1'b0;
        fill_const('0);
        load();
        repeat (2) @(negedge clk);
        check("rst_busy0", 64'(bus.busy), 64'd0);
        check("rst_done0", 64'(bus.done), 64'd0);
        check("rst_wr0",   64'(bus.wr),   64'd0);
        check("rst_idx0",  64'({bus.rx, bus.ry, bus.wx, bus.wy}), 64'd0);
        check("rst_wd0",   bus.wd, 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", 64'(bus.busy), 64'd0);
        check("idle_wr",   64'(bus.wr),   64'd0);

        // All-zero state
        snap_exp(); model_step();
        run_pass(-1, dk, wf, wc, vc);
        check("zero_done_lat", 64'(dk), 64'd52);
        check("zero_wr_first", 64'(wf), 64'd27);
        check("zero_wr_cnt",   64'(wc), 64'd25);
        cmp_mem("zero");

        // Single bit at (0,0)
        fill_const('0);
        ld_img[0][0] = 64'h1;
        load();
        run_pass(-1, dk, wf, wc, vc);
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++) begin
                want = (x == 1) ? 64'h1 : (x == 4) ? 64'h2 : (x == 0 && y == 0) ? 64'h1 : 64'h0;
                check($sformatf("one_lane%0d%0d", x, y), mem[x][y], want);
            end

        // Memory in its power-up pattern
        fill_const(64'hdeaddeaddeaddead);
        load();
        run_pass(-1, dk, wf, wc, vc);
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                check($sformatf("dead_lane%0d%0d", x, y), mem[x][y], 64'hbd5bbd5bbd5bbd5b);

        // Random states
        for (int t = 0; t < 3; t++) begin
            fill_rand();
            load();
            snap_exp(); model_step();
            run_pass(-1, dk, wf, wc, vc);
            check("rand_done_lat", 64'(dk), 64'd52);
            cmp_mem("rand");
        end

        // start held high: back-to-back passes
        fill_rand();
        load();
        snap_exp(); model_step(); model_step();
        d1 = 0; d2 = 0; wc = 0;
        @(negedge clk) bus.start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 106; k++) begin
            @(negedge clk);
            if (bus.wr) wc++;
            if (bus.done) begin
                if (d1 == 0) d1 = k;
                else if (d2 == 0) d2 = k;
            end
            if (k == 106) bus.start = 1'b0;
        end
        check("held_done1", 64'(d1), 64'd52);
        check("held_done2", 64'(d2), 64'd105);
        check("held_wr_cnt", 64'(wc), 64'd50);
        repeat (4) @(negedge clk);
        check("held_idle_busy", 64'(bus.busy), 64'd0);
        cmp_mem("held");

        // Reset in the 10th apply cycle
        fill_rand();
        load();
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++) orig[x][y] = mem[x][y];
        snap_exp(); model_step();
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                if (y * 5 + x >= 10) exp_m[x][y] = orig[x][y];
        run_pass(36, dk, wf, wc, vc);
        check("abort_wr_cnt", 64'(wc), 64'd10);
        check("abort_no_done", 64'(dk), 64'd0);
        cmp_mem("abort");
        snap_exp(); model_step();
        run_pass(-1, dk, wf, wc, vc);
        check("after_abort_lat", 64'(dk), 64'd52);
        cmp_mem("after_abort");

`ifdef THETA_PAR_OUT_EN
        fill_const('0);
        ld_img[2][3] = 64'hF0;
        load();
        run_pass(-1, dk, wf, wc, vc);
        check("par_vld_cnt", 64'(vc), 64'd1);
        for (int x = 0; x < 5; x++) begin
            check($sformatf("par_slice%0d", x), par_cap[x*W +: W], (x == 2) ? 64'hF0 : 64'h0);
            check($sformatf("par_hold%0d", x), par_out[x*W +: W], (x == 2) ? 64'hF0 : 64'h0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
